axi_rr_arbiter: RTL and testbench

AXI_RR_ARBITER -- requirements
Module: axi_rr_arbiter

---
 rtl/axi_rr_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_axi_rr_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rr_arbiter.sv
// Round-robin AXI arbiter: NM masters onto one slave, independent read/write paths, one outstanding each.
// Latency: 1-cycle arbitration then pass-through; backpressure follows slave readies, grant held until response.
module axi_rr_arbiter #(
  parameter int NM = 4,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  // master AR / R
  input  logic [NM*AW-1:0]   m_araddr,
  input  logic [NM*3-1:0]    m_arsize,
  input  logic [NM-1:0]      m_arvalid,
  output logic [NM-1:0]      m_arready,
  output logic [NM*DW-1:0]   m_rdata,
  output logic [NM*2-1:0]    m_rresp,
  output logic [NM-1:0]      m_rvalid,
  input  logic [NM-1:0]      m_rready,
  // master AW / W / B
  input  logic [NM*AW-1:0]   m_awaddr,
  input  logic [NM-1:0]      m_awvalid,
  output logic [NM-1:0]      m_awready,
  input  logic [NM*DW-1:0]   m_wdata,
  input  logic [NM*DW/8-1:0] m_wstrb,
  input  logic [NM-1:0]      m_wvalid,
  output logic [NM-1:0]      m_wready,
  output logic [NM*2-1:0]    m_bresp,
  output logic [NM-1:0]      m_bvalid,
  input  logic [NM-1:0]      m_bready,
  // slave side
  output logic [AW-1:0]      s_araddr,
  output logic [2:0]         s_arsize,
  output logic               s_arvalid,
  input  logic               s_arready,
  input  logic [DW-1:0]      s_rdata,
  input  logic [1:0]         s_rresp,
  input  logic               s_rvalid,
  output logic               s_rready,
  output logic [AW-1:0]      s_awaddr,
  output logic               s_awvalid,
  input  logic               s_awready,
  output logic [DW-1:0]      s_wdata,
  output logic [DW/8-1:0]    s_wstrb,
  output logic               s_wvalid,
  input  logic               s_wready,
  input  logic [1:0]         s_bresp,
  input  logic               s_bvalid,
  output logic               s_bready,
  // debug
  output logic [NM-1:0]      rd_grant,
  output logic [NM-1:0]      wr_grant
);

  localparam int PW = $clog2(NM);
  localparam int SW = DW / 8;
  localparam logic [NM-1:0] ONE = NM'(1);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wr_state_t;

  // First requester at or after ptr, wrapping NM-1 -> 0; lowest offset wins.
  function automatic logic [PW-1:0] rr_pick(input logic [NM-1:0] req, input logic [PW-1:0] ptr);
    int j;
    rr_pick = ptr;
    for (int k = NM - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NM) j = j - NM;
      if (req[j[PW-1:0]]) rr_pick = j[PW-1:0];
    end
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == NM - 1) ? '0 : p + PW'(1);
  endfunction

  rd_state_t       rd_state, rd_next;
  wr_state_t       wr_state, wr_next;
  logic [PW-1:0]   rd_ptr, rd_idx, wr_ptr, wr_idx;
  logic            aw_done, w_done;
  logic            r_hs, aw_hs, w_hs, b_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= R_IDLE;
      wr_state <= W_IDLE;
    end else begin
      rd_state <= rd_next;
      wr_state <= wr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      rd_idx   <= '0;
      rd_grant <= '0;
    end else if (rd_state == R_IDLE && |m_arvalid) begin
      rd_idx   <= rr_pick(m_arvalid, rd_ptr);
      rd_grant <= ONE << rr_pick(m_arvalid, rd_ptr);
    end else if (r_hs) begin
      rd_ptr   <= ptr_inc(rd_idx);
      rd_grant <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      wr_idx   <= '0;
      wr_grant <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else if (wr_state == W_IDLE && |m_awvalid) begin
      wr_idx   <= rr_pick(m_awvalid, wr_ptr);
      wr_grant <= ONE << rr_pick(m_awvalid, wr_ptr);
    end else if (b_hs) begin
      wr_ptr   <= ptr_inc(wr_idx);
      wr_grant <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

  always_comb begin
    rd_next   = rd_state;
    r_hs      = 1'b0;
    s_araddr  = '0;
    s_arsize  = 3'b010;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    m_arready = '0;
    m_rdata   = '0;
    m_rresp   = '0;
    m_rvalid  = '0;
    case (rd_state)
      R_IDLE: if (|m_arvalid) rd_next = R_ADDR;
      R_ADDR: begin
        s_araddr          = m_araddr[rd_idx*AW +: AW];
        s_arsize          = m_arsize[rd_idx*3 +: 3];
        s_arvalid         = m_arvalid[rd_idx];
        m_arready[rd_idx] = s_arready;
        if (m_arvalid[rd_idx] && s_arready) rd_next = R_DATA;
      end
      R_DATA: begin
        m_rdata[rd_idx*DW +: DW] = s_rdata;
        m_rresp[rd_idx*2 +: 2]   = s_rresp;
        m_rvalid[rd_idx]         = s_rvalid;
        s_rready                 = m_rready[rd_idx];
        r_hs                     = s_rvalid && m_rready[rd_idx];
        if (r_hs) rd_next = R_IDLE;
      end
      default: rd_next = R_IDLE;
    endcase
  end

  // AW and W forward independently; a finished channel stays quiet until B completes.
  always_comb begin
    wr_next   = wr_state;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    b_hs      = 1'b0;
    s_awaddr  = '0;
    s_awvalid = 1'b0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    m_awready = '0;
    m_wready  = '0;
    m_bresp   = '0;
    m_bvalid  = '0;
    case (wr_state)
      W_IDLE: if (|m_awvalid) wr_next = W_REQ;
      W_REQ: begin
        s_awaddr = m_awaddr[wr_idx*AW +: AW];
        s_wdata  = m_wdata[wr_idx*DW +: DW];
        s_wstrb  = m_wstrb[wr_idx*SW +: SW];
        if (!aw_done) begin
          s_awvalid         = m_awvalid[wr_idx];
          m_awready[wr_idx] = s_awready;
          aw_hs             = m_awvalid[wr_idx] && s_awready;
        end
        if (!w_done) begin
          s_wvalid         = m_wvalid[wr_idx];
          m_wready[wr_idx] = s_wready;
          w_hs             = m_wvalid[wr_idx] && s_wready;
        end
        if ((aw_done || aw_hs) && (w_done || w_hs)) wr_next = W_RESP;
      end
      W_RESP: begin
        m_bresp[wr_idx*2 +: 2] = s_bresp;
        m_bvalid[wr_idx]       = s_bvalid;
        s_bready               = m_bready[wr_idx];
        b_hs                   = s_bvalid && m_bready[wr_idx];
        if (b_hs) wr_next = W_IDLE;
      end
      default: wr_next = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Directed bench for axi_rr_arbiter: reset, single read, fairness, split write, concurrency, mid-read reset, SLVERR.
module tb_axi_rr_arbiter;
  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [NM*AW-1:0]   m_araddr, m_awaddr;
  logic [NM*3-1:0]    m_arsize;
  logic [NM-1:0]      m_arvalid, m_arready, m_rvalid, m_rready;
  logic [NM*DW-1:0]   m_rdata, m_wdata;
  logic [NM*2-1:0]    m_rresp, m_bresp;
  logic [NM-1:0]      m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [NM*DW/8-1:0] m_wstrb;
  logic [AW-1:0]      s_araddr, s_awaddr;
  logic [2:0]         s_arsize;
  logic               s_arvalid, s_arready, s_rvalid, s_rready;
  logic [DW-1:0]      s_rdata, s_wdata;
  logic [1:0]         s_rresp, s_bresp;
  logic               s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [DW/8-1:0]    s_wstrb;
  logic [NM-1:0]      rd_grant, wr_grant;

  int checks = 0;
  int errors = 0;

  axi_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_araddr(m_araddr), .m_arsize(m_arsize), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_araddr(s_araddr), .s_arsize(s_arsize), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .rd_grant(rd_grant), .wr_grant(wr_grant)
  );

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs;
    m_araddr = '0; m_arsize = '0; m_arvalid = '0; m_rready = '0;
    m_awaddr = '0; m_awvalid = '0; m_wdata = '0; m_wstrb = '0; m_wvalid = '0; m_bready = '0;
    s_arready = 1'b0; s_rdata = '0; s_rresp = '0; s_rvalid = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0; s_bresp = '0; s_bvalid = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    idle_inputs;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (rd_grant !== 4'b0000) begin errors++; $display("FAIL reset_rd_grant got %b exp 0000", rd_grant); end
    checks++; if (wr_grant !== 4'b0000) begin errors++; $display("FAIL reset_wr_grant got %b exp 0000", wr_grant); end
    checks++; if ({s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready} !== 5'b0) begin errors++; $display("FAIL reset_slave_hs got %b exp 00000", {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready}); end
    checks++; if ({m_arready, m_rvalid, m_awready, m_wready, m_bvalid} !== 20'h0) begin errors++; $display("FAIL reset_master_hs got %h exp 00000", {m_arready, m_rvalid, m_awready, m_wready, m_bvalid}); end
    checks++; if (s_arsize !== 3'b010) begin errors++; $display("FAIL reset_arsize got %b exp 010", s_arsize); end
    checks++; if ({dut.rd_ptr, dut.wr_ptr, dut.aw_done, dut.w_done} !== 6'b0) begin errors++; $display("FAIL reset_ptrs got %b exp 000000", {dut.rd_ptr, dut.wr_ptr, dut.aw_done, dut.w_done}); end
    m_arvalid = 4'b1111; m_awvalid = 4'b1111; s_arready = 1'b1; s_awready = 1'b1;
    tick;
    tick;
    checks++; if ({rd_grant, wr_grant, s_arvalid, s_awvalid} !== 10'b0) begin errors++; $display("FAIL reset_held_req got %b exp 0", {rd_grant, wr_grant, s_arvalid, s_awvalid}); end
    idle_inputs;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_single_read;
    idle_inputs;
    s_arready = 1'b1;
    m_araddr[2*AW +: AW] = 32'h8000_0010;
    m_arsize[2*3 +: 3] = 3'b010;
    m_arvalid = 4'b0100;
    #1;
    checks++; if ({s_arvalid, m_arready} !== 5'b0) begin errors++; $display("FAIL rd_cycle0_quiet got %b exp 00000", {s_arvalid, m_arready}); end
    tick;
    checks++; if (rd_grant !== 4'b0100) begin errors++; $display("FAIL rd_grant got %b exp 0100", rd_grant); end
    checks++; if (s_arvalid !== 1'b1 || s_araddr !== 32'h8000_0010) begin errors++; $display("FAIL rd_ar_fwd got v=%b a=%h exp v=1 a=80000010", s_arvalid, s_araddr); end
    checks++; if (m_arready !== 4'b0100) begin errors++; $display("FAIL rd_arready got %b exp 0100", m_arready); end
    tick;
    m_arvalid = '0; s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b00; m_rready = 4'b0100;
    #1;
    checks++; if (m_rdata[2*DW +: DW] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rdata got %h exp deadbeef", m_rdata[2*DW +: DW]); end
    checks++; if (m_rvalid !== 4'b0100 || s_rready !== 1'b1) begin errors++; $display("FAIL rd_rvalid got %b/%b exp 0100/1", m_rvalid, s_rready); end
    checks++; if (m_rdata[0 +: DW] !== 32'h0) begin errors++; $display("FAIL rd_other_data got %h exp 0", m_rdata[0 +: DW]); end
    tick;
    idle_inputs;
    #1;
    checks++; if (rd_grant !== 4'b0000 || dut.rd_ptr !== 2'd3) begin errors++; $display("FAIL rd_done got grant=%b ptr=%0d exp 0000/3", rd_grant, dut.rd_ptr); end
  endtask

  task automatic test_fairness;
    logic [NM-1:0] exp_g [5];
    logic [NM-1:0] seen;
    int waited;
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    seen = '0;
    do_reset;
    idle_inputs;
    m_arvalid = 4'b1111; s_arready = 1'b1; s_rvalid = 1'b1; m_rready = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      waited = 0;
      while (rd_grant == 4'b0000 && waited < 8) begin tick; waited++; end
      checks++; if (rd_grant !== exp_g[n]) begin errors++; $display("FAIL fair_grant_%0d got %b exp %b", n, rd_grant, exp_g[n]); end
      if (n < 4) seen = seen | rd_grant;
      while (rd_grant != 4'b0000 && waited < 16) begin tick; waited++; end
    end
    idle_inputs;
    checks++; if (seen !== 4'b1111) begin errors++; $display("FAIL fair_all_served got %b exp 1111", seen); end
    tick;
  endtask

  task automatic test_write_w_first;
    idle_inputs;
    s_wready = 1'b1; s_awready = 1'b0;
    m_wdata[1*DW +: DW] = 32'hCAFE_0001; m_wstrb[1*4 +: 4] = 4'hF; m_wvalid = 4'b0010;
    #1;
    checks++; if ({s_wvalid, m_wready} !== 5'b0) begin errors++; $display("FAIL wr_w_idle got %b exp 00000", {s_wvalid, m_wready}); end
    tick;
    tick;
    tick;
    m_awvalid = 4'b0010; m_awaddr[1*AW +: AW] = 32'h0000_1000;
    #1;
    checks++; if (wr_grant !== 4'b0000) begin errors++; $display("FAIL wr_no_grant_on_w got %b exp 0000", wr_grant); end
    tick;
    checks++; if (wr_grant !== 4'b0010) begin errors++; $display("FAIL wr_grant got %b exp 0010", wr_grant); end
    checks++; if (s_wvalid !== 1'b1 || s_wdata !== 32'hCAFE_0001 || s_wstrb !== 4'hF) begin errors++; $display("FAIL wr_w_fwd got v=%b d=%h s=%h exp 1/cafe0001/f", s_wvalid, s_wdata, s_wstrb); end
    checks++; if (m_wready !== 4'b0010 || s_awvalid !== 1'b1 || m_awready !== 4'b0000) begin errors++; $display("FAIL wr_split got wr=%b awv=%b awr=%b exp 0010/1/0000", m_wready, s_awvalid, m_awready); end
    tick;
    checks++; if (s_wvalid !== 1'b0 || m_wready !== 4'b0000) begin errors++; $display("FAIL wr_w_dropped got v=%b r=%b exp 0/0000", s_wvalid, m_wready); end
    checks++; if (s_awvalid !== 1'b1 || s_awaddr !== 32'h0000_1000) begin errors++; $display("FAIL wr_aw_pending got v=%b a=%h exp 1/00001000", s_awvalid, s_awaddr); end
    s_awready = 1'b1;
    #1;
    checks++; if (m_awready !== 4'b0010) begin errors++; $display("FAIL wr_awready got %b exp 0010", m_awready); end
    tick;
    m_awvalid = '0; m_wvalid = '0; s_bvalid = 1'b1; s_bresp = 2'b00; m_bready = 4'b0010;
    #1;
    checks++; if (m_bvalid !== 4'b0010 || s_bready !== 1'b1) begin errors++; $display("FAIL wr_bvalid got %b/%b exp 0010/1", m_bvalid, s_bready); end
    tick;
    idle_inputs;
    #1;
    checks++; if (wr_grant !== 4'b0000 || dut.wr_ptr !== 2'd2) begin errors++; $display("FAIL wr_done got grant=%b ptr=%0d exp 0000/2", wr_grant, dut.wr_ptr); end
  endtask

  task automatic test_simultaneous;
    idle_inputs;
    s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
    m_arvalid = 4'b0001; m_araddr[0 +: AW] = 32'h0000_0100;
    m_awvalid = 4'b1000; m_awaddr[3*AW +: AW] = 32'h0000_0200;
    m_wvalid = 4'b1000; m_wdata[3*DW +: DW] = 32'h5555_AAAA; m_wstrb[3*4 +: 4] = 4'h3;
    tick;
    checks++; if ({rd_grant, wr_grant} !== 8'b0001_1000) begin errors++; $display("FAIL sim_grants got %b exp 00011000", {rd_grant, wr_grant}); end
    checks++; if ({s_arvalid, s_awvalid, s_wvalid} !== 3'b111) begin errors++; $display("FAIL sim_fwd got %b exp 111", {s_arvalid, s_awvalid, s_wvalid}); end
    tick;
    m_arvalid = '0; m_awvalid = '0; m_wvalid = '0;
    s_rvalid = 1'b1; s_rdata = 32'h0BAD_F00D; m_rready = 4'b0001;
    s_bvalid = 1'b1; m_bready = 4'b1000;
    #1;
    checks++; if ({m_rvalid, m_bvalid} !== 8'b0001_1000) begin errors++; $display("FAIL sim_resp got %b exp 00011000", {m_rvalid, m_bvalid}); end
    checks++; if (m_rdata[0 +: DW] !== 32'h0BAD_F00D) begin errors++; $display("FAIL sim_rdata got %h exp 0badf00d", m_rdata[0 +: DW]); end
    tick;
    idle_inputs;
    #1;
    checks++; if ({rd_grant, wr_grant} !== 8'b0 || dut.rd_ptr !== 2'd1 || dut.wr_ptr !== 2'd0) begin errors++; $display("FAIL sim_done got g=%b rp=%0d wp=%0d exp 0/1/0", {rd_grant, wr_grant}, dut.rd_ptr, dut.wr_ptr); end
  endtask

  task automatic test_reset_mid;
    idle_inputs;
    m_arvalid = 4'b0100; s_arready = 1'b1;
    tick;
    tick;
    m_arvalid = '0; s_rvalid = 1'b1; s_rdata = 32'h1234_5678;
    #1;
    checks++; if (m_rvalid !== 4'b0100) begin errors++; $display("FAIL mid_in_rdata got %b exp 0100", m_rvalid); end
    rst_n = 1'b0; m_rready = 4'b1111;
    #1;
    checks++; if ({rd_grant, m_rvalid, s_rready} !== 9'b0) begin errors++; $display("FAIL mid_async_clear got %b exp 0", {rd_grant, m_rvalid, s_rready}); end
    checks++; if (m_rdata !== '0) begin errors++; $display("FAIL mid_rdata_zero got %h exp 0", m_rdata); end
    tick;
    idle_inputs;
    rst_n = 1'b1;
    tick;
    m_arvalid = 4'b1111; s_arready = 1'b0;
    tick;
    checks++; if (rd_grant !== 4'b0001) begin errors++; $display("FAIL mid_restart_grant got %b exp 0001", rd_grant); end
    idle_inputs;
    do_reset;
  endtask

  task automatic test_error_resp;
    idle_inputs;
    s_awready = 1'b1; s_wready = 1'b1;
    m_awvalid = 4'b0100; m_wvalid = 4'b0100;
    tick;
    checks++; if (wr_grant !== 4'b0100) begin errors++; $display("FAIL err_grant got %b exp 0100", wr_grant); end
    tick;
    m_awvalid = '0; m_wvalid = '0; s_bvalid = 1'b1; s_bresp = 2'b10; m_bready = 4'b0100;
    #1;
    checks++; if (m_bresp[2*2 +: 2] !== 2'b10 || m_bvalid !== 4'b0100) begin errors++; $display("FAIL err_bresp got r=%b v=%b exp 10/0100", m_bresp[2*2 +: 2], m_bvalid); end
    checks++; if ((m_bresp & 8'b1100_1111) !== 8'b0) begin errors++; $display("FAIL err_other_bresp got %b exp 0", m_bresp); end
    tick;
    idle_inputs;
    #1;
    checks++; if (wr_grant !== 4'b0000 || dut.wr_ptr !== 2'd3) begin errors++; $display("FAIL err_ptr got grant=%b ptr=%0d exp 0000/3", wr_grant, dut.wr_ptr); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_single_read;
    test_fairness;
    test_write_w_first;
    test_simultaneous;
    test_reset_mid;
    test_error_resp;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
